// File: rtl/queue_ctrl.sv
// queue_ctrl: pointer and occupancy controller for a single-write / single-read queue memory.
// Qualifies push/pop against full/empty, drives memory enables and addresses, and keeps
// occupancy, threshold flags and sticky overflow/underflow flags.
module queue_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned   DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AeCnt    = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Status flags decode only from the registered occupancy.
    always_comb begin
        full         = (count_q == DepthCnt);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AfCnt);
        almost_empty = (count_q <= AeCnt);
    end

    // Qualify requests; a push while full is refused even if a pop is accepted alongside it.
    always_comb begin
        wr_en = push & ~full;
        rd_en = pop & ~empty;
    end

    // Next-state for pointers, occupancy, read-valid pipeline and sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_en;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Pointers wrap naturally at DEPTH through ADDR_W overflow.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle error event takes priority.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push && full) begin
            overflow_d = 1'b1;
        end
        if (pop && empty) begin
            underflow_d = 1'b1;
        end
    end

    // State registers; reset discards all queue contents immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Registered outputs driven straight from state.
    always_comb begin
        wr_addr   = wr_ptr_q;
        rd_addr   = rd_ptr_q;
        count     = count_q;
        rd_valid  = rd_valid_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl: table-driven directed check of queue_ctrl (ADDR_W=4, AF=14, AE=2),
// plus hand-written reset sequences.
module tb_queue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    queue_ctrl #(
        .ADDR_W  (4),
        .AF_LEVEL(14),
        .AE_LEVEL(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic push;
        logic pop;
        logic clr;
        logic x_wen;
        logic x_ren;
        int   x_cnt;
        int   x_wa;
        int   x_ra;
        logic x_rv;
        logic x_ovf;
        logic x_unf;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic p, input logic q, input logic c,
                                input logic wen, input logic ren, input int cnt,
                                input int wa, input int ra, input logic rv,
                                input logic ovf, input logic unf);
        vec_t v;
        v.push  = p;
        v.pop   = q;
        v.clr   = c;
        v.x_wen = wen;
        v.x_ren = ren;
        v.x_cnt = cnt;
        v.x_wa  = wa;
        v.x_ra  = ra;
        v.x_rv  = rv;
        v.x_ovf = ovf;
        v.x_unf = unf;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    // Compare all registered outputs plus flags derived from the expected occupancy.
    task automatic check_state(input int idx, input int cnt, input int wa, input int ra,
                               input logic rv, input logic ovf, input logic unf);
        check("count", idx, int'(count), cnt);
        check("full", idx, int'(full), int'(cnt == 16));
        check("empty", idx, int'(empty), int'(cnt == 0));
        check("almost_full", idx, int'(almost_full), int'(cnt >= 14));
        check("almost_empty", idx, int'(almost_empty), int'(cnt <= 2));
        check("wr_addr", idx, int'(wr_addr), wa);
        check("rd_addr", idx, int'(rd_addr), ra);
        check("rd_valid", idx, int'(rd_valid), int'(rv));
        check("overflow", idx, int'(overflow), int'(ovf));
        check("underflow", idx, int'(underflow), int'(unf));
    endtask

    task automatic step(input logic p, input logic q, input logic c);
        @(negedge clk);
        push    = p;
        pop     = q;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;

        // Vector table: push, pop, clr, wr_en, rd_en, count, wr_addr, rd_addr, rv, ovf, unf
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 0, 0, 1, 0, i + 1, (i + 1) % 16, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16, 0, 0, 0, 1, 0);   // 17th push rejected
        add(0, 0, 1, 0, 0, 16, 0, 0, 0, 0, 0);   // clr alone
        add(1, 0, 1, 0, 0, 16, 0, 0, 0, 1, 0);   // set beats clear
        add(0, 0, 1, 0, 0, 16, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 1, 15 - i, 0, (i + 1) % 16, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);    // pop while empty
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1);    // empty push+pop: write only
        add(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 1, 0, i + 2, i + 2, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 1, 0, 1, 1, 8, (9 + i) % 16, (i + 1) % 16, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 1, 0, 9 + i, (13 + i) % 16, 4, 0, 0, 0);
        add(1, 0, 0, 1, 0, 16, 4, 4, 0, 0, 0);
        add(1, 1, 0, 0, 1, 15, 4, 5, 1, 1, 0);   // full push+pop: read only

        // Reset held low: outputs at reset values before any released edge.
        #12;
        check_state(-1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[k]) begin
            @(negedge clk);
            push    = vq[k].push;
            pop     = vq[k].pop;
            clr_err = vq[k].clr;
            #1;
            check("wr_en", k, int'(wr_en), int'(vq[k].x_wen));
            check("rd_en", k, int'(rd_en), int'(vq[k].x_ren));
            @(posedge clk);
            #1;
            check_state(k, vq[k].x_cnt, vq[k].x_wa, vq[k].x_ra, vq[k].x_rv,
                        vq[k].x_ovf, vq[k].x_unf);
        end

        // Clean restart, then build count=9 with rd_valid high.
        @(negedge clk);
        push  = 1'b0;
        pop   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        step(0, 1, 0);
        check("pre_rst_count", 100, int'(count), 9);
        check("pre_rst_rd_valid", 100, int'(rd_valid), 1);
        check("pre_rst_wr_addr", 100, int'(wr_addr), 10);
        check("pre_rst_rd_addr", 100, int'(rd_addr), 1);

        // Async reset mid-cycle while clk is high: no edge needed.
        #1;
        push  = 1'b1;
        rst_n = 1'b0;
        #1;
        check_state(101, 0, 0, 0, 0, 0, 0);
        check("rst_wr_en_push", 101, int'(wr_en), 1);
        @(negedge clk);
        push  = 1'b0;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
